// File: rtl/bus_rr_xbar.sv
// N-host to M-device bus interconnect: round-robin arbitration, address decode,
// one-cycle registered responses and decode-error reporting with a saturating count.
module bus_rr_xbar #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int ErrCntWidth  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrHosts-1:0]                  host_req_i,
    input  logic [NrHosts*AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                  host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                  host_gnt_o,
    output logic [NrHosts-1:0]                  host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                  host_err_o,
    output logic [NrDevices-1:0]                device_req_o,
    output logic [NrDevices*AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices-1:0]                device_we_o,
    output logic [NrDevices*(DataWidth/8)-1:0]  device_be_o,
    output logic [NrDevices*DataWidth-1:0]      device_wdata_o,
    input  logic [NrDevices*DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices*AddressWidth-1:0]   cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0]   cfg_device_addr_mask_i,
    output logic [ErrCntWidth-1:0]              err_cnt_o
);
    localparam int BeWidth  = DataWidth / 8;
    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostIdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [HostIdxW-1:0]    rsp_host_q, rsp_host_d;
    logic [DevIdxW-1:0]     rsp_dev_q, rsp_dev_d;
    logic                   rsp_we_q, rsp_we_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    logic                    gnt_any;
    logic                    gnt_valid;
    logic [HostIdxW-1:0]     gnt_idx;
    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeWidth-1:0]      sel_be;
    logic [DataWidth-1:0]    sel_wdata;
    logic                    dec_hit;
    logic [DevIdxW-1:0]      dec_idx;
    logic                    rsp_live;
    logic [DataWidth-1:0]    rsp_rdata;

    // Search starts at rr_ptr and wraps, so the last-granted host has lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NrHosts; k++) begin
            if (!gnt_any && host_req_i[(int'(rr_ptr_q) + k) % NrHosts]) begin
                gnt_any = 1'b1;
                gnt_idx = HostIdxW'((int'(rr_ptr_q) + k) % NrHosts);
            end
        end
    end

    assign gnt_valid = gnt_any && !rst_i;
    assign sel_addr  = host_addr_i[gnt_idx*AddressWidth +: AddressWidth];
    assign sel_we    = host_we_i[gnt_idx];
    assign sel_be    = host_be_i[gnt_idx*BeWidth +: BeWidth];
    assign sel_wdata = host_wdata_i[gnt_idx*DataWidth +: DataWidth];

    // Lowest-index match wins when windows overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dec_hit && ((sel_addr & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth])
                             == cfg_device_addr_base_i[d*AddressWidth +: AddressWidth])) begin
                dec_hit = 1'b1;
                dec_idx = DevIdxW'(d);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_gnt
            assign host_gnt_o[gi] = gnt_valid && (gnt_idx == HostIdxW'(gi));
        end
        for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
            assign device_req_o[gi] = gnt_valid && dec_hit && (dec_idx == DevIdxW'(gi));
            assign device_addr_o[gi*AddressWidth +: AddressWidth] = gnt_valid ? sel_addr : '0;
            assign device_we_o[gi]                                = gnt_valid && sel_we;
            assign device_be_o[gi*BeWidth +: BeWidth]             = gnt_valid ? sel_be : '0;
            assign device_wdata_o[gi*DataWidth +: DataWidth]      = gnt_valid ? sel_wdata : '0;
        end
    endgenerate

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = 1'b0;
        rsp_host_d  = rsp_host_q;
        rsp_dev_d   = rsp_dev_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        if (gnt_valid) begin
            rr_ptr_d    = (gnt_idx == HostIdxW'(NrHosts - 1)) ? '0 : gnt_idx + 1'b1;
            rsp_valid_d = 1'b1;
            rsp_host_d  = gnt_idx;
            rsp_dev_d   = dec_idx;
            rsp_we_d    = sel_we;
            rsp_err_d   = !dec_hit;
            if (!dec_hit && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_host_q  <= '0;
            rsp_dev_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_host_q  <= rsp_host_d;
            rsp_dev_q   <= rsp_dev_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Device read data is only forwarded for a mapped read; writes and errors return zero.
    assign rsp_live  = rsp_valid_q && !rst_i;
    assign rsp_rdata = (rsp_we_q || rsp_err_q) ? '0
                     : device_rdata_i[rsp_dev_q*DataWidth +: DataWidth];

    generate
        for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_rsp
            logic sel;
            assign sel                                     = rsp_live && (rsp_host_q == HostIdxW'(gi));
            assign host_rvalid_o[gi]                       = sel;
            assign host_err_o[gi]                          = sel && rsp_err_q;
            assign host_rdata_o[gi*DataWidth +: DataWidth] = sel ? rsp_rdata : '0;
        end
    endgenerate

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Bench for bus_rr_xbar: directed scenarios plus randomized traffic checked
// against an address-range/round-robin reference model.
module tb_bus_rr_xbar;
    localparam int NH = 2;
    localparam int ND = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic [NH-1:0]    host_req;
    logic [NH*AW-1:0] host_addr;
    logic [NH-1:0]    host_we;
    logic [NH*BW-1:0] host_be;
    logic [NH*DW-1:0] host_wdata;
    logic [NH-1:0]    gnt, rvalid, herr;
    logic [NH*DW-1:0] rdata;
    logic [ND-1:0]    dreq, dwe;
    logic [ND*AW-1:0] daddr;
    logic [ND*BW-1:0] dbe;
    logic [ND*DW-1:0] dwdata;
    logic [ND*DW-1:0] drdata;
    logic [ND*AW-1:0] cfg_base, cfg_mask;
    logic [15:0]      err_cnt;

    logic [NH-1:0]    s_gnt, s_rvalid, s_herr;
    logic [NH*DW-1:0] s_rdata;
    logic [ND-1:0]    s_dreq, s_dwe;
    logic [ND*AW-1:0] s_daddr;
    logic [ND*BW-1:0] s_dbe;
    logic [ND*DW-1:0] s_dwdata;
    logic [1:0]       s_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign cfg_base = {32'h0020_0000, 32'h0000_0000};
    assign cfg_mask = {32'hFFFF_0000, 32'hFFF0_0000};

    bus_rr_xbar #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .ErrCntWidth(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_addr_i(host_addr), .host_we_i(host_we),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(gnt), .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(herr),
        .device_req_o(dreq), .device_addr_o(daddr), .device_we_o(dwe),
        .device_be_o(dbe), .device_wdata_o(dwdata), .device_rdata_i(drdata),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask),
        .err_cnt_o(err_cnt)
    );

    bus_rr_xbar #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .ErrCntWidth(2)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_addr_i(host_addr), .host_we_i(host_we),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(s_gnt), .host_rvalid_o(s_rvalid), .host_rdata_o(s_rdata), .host_err_o(s_herr),
        .device_req_o(s_dreq), .device_addr_o(s_daddr), .device_we_o(s_dwe),
        .device_be_o(s_dbe), .device_wdata_o(s_dwdata), .device_rdata_i(drdata),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask),
        .err_cnt_o(s_err_cnt)
    );

    // Device content: device 0 at 0x10 returns 0xDEADBEEF.
    function automatic logic [31:0] dev_data(int d, logic [31:0] a);
        return (d == 0) ? (a ^ 32'hDEAD_BEFF) : (a ^ 32'h1234_5678);
    endfunction

    // Synchronous-RAM style devices: data appears the cycle after the request.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (dreq[d]) drdata[d*DW +: DW] <= dev_data(d, daddr[d*AW +: AW]);
        end
    end

    // Memory map as ranges: RAM 0x0000_0000-0x000F_FFFF, console 0x0020_0000-0x0020_FFFF.
    function automatic int ref_decode(logic [31:0] a);
        if (a < 32'h0010_0000) return 0;
        if (a >= 32'h0020_0000 && a < 32'h0021_0000) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(0, 32'h000F_FFFF));
            1:       a = 32'h0020_0000 + 32'($urandom_range(0, 32'h0000_FFFF));
            2:       a = 32'h8000_0000 | 32'($urandom);
            default: a = 32'h0010_0000 + 32'($urandom_range(0, 32'h000F_FFFF));
        endcase
        return a;
    endfunction

    task automatic drive_host(int h, logic req, logic [31:0] a, logic we, logic [31:0] wd);
        host_req[h]             = req;
        host_addr[h*AW +: AW]   = a;
        host_we[h]              = we;
        host_be[h*BW +: BW]     = 4'hF;
        host_wdata[h*DW +: DW]  = wd;
    endtask

    task automatic clear_hosts();
        host_req   = '0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_host(0, 1'b1, 32'h10, 1'b0, 32'h0);
        drive_host(1, 1'b1, 32'h0020_0000, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 2'b00)    begin n_fail++; $display("FAIL reset_gnt c%0d: got %b want 00", c, gnt); end
            n_checks++; if (dreq !== 2'b00)   begin n_fail++; $display("FAIL reset_dreq c%0d: got %b want 00", c, dreq); end
            n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid c%0d: got %b want 00", c, rvalid); end
            n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_errcnt c%0d: got %0d want 0", c, err_cnt); end
            next_cycle();
        end
        $display("reset: 2 cycles held with both hosts requesting");
        rst = 1'b0;
        clear_hosts();
    endtask

    task automatic test_single_read();
        drive_host(0, 1'b1, 32'h10, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b01)  begin n_fail++; $display("FAIL rd_gnt: got %b want 01", gnt); end
        n_checks++; if (dreq !== 2'b01) begin n_fail++; $display("FAIL rd_dreq: got %b want 01", dreq); end
        n_checks++; if (daddr !== {2{32'h10}}) begin n_fail++; $display("FAIL rd_daddr: got %h want %h", daddr, {2{32'h10}}); end
        next_cycle();
        clear_hosts();
        @(negedge clk);
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
        n_checks++; if (rdata !== {32'h0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rd_rdata: got %h want 00000000deadbeef", rdata); end
        n_checks++; if (herr !== 2'b00) begin n_fail++; $display("FAIL rd_err: got %b want 00", herr); end
        $display("txn: H0 read 0x00000010 -> %h", rdata[31:0]);
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        rst = 1'b1; next_cycle(); rst = 1'b0;
        drive_host(0, 1'b1, 32'h20, 1'b0, 32'h0);
        drive_host(1, 1'b1, 32'h24, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++; if (gnt !== want) begin n_fail++; $display("FAIL rr_order c%0d: got %b want %b", c, gnt, want); end
            $display("txn: round-robin cycle %0d gnt=%b", c, gnt);
            next_cycle();
        end
        // One solo H0 grant leaves the pointer at 1, so H1 wins the next tie.
        drive_host(1, 1'b0, 32'h24, 1'b0, 32'h0);
        next_cycle();
        drive_host(1, 1'b1, 32'h24, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rr_ptr1: got %b want 10", gnt); end
        next_cycle();
        clear_hosts();
    endtask

    task automatic test_write();
        drive_host(1, 1'b1, 32'h0020_0000, 1'b1, 32'h41);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b10)  begin n_fail++; $display("FAIL wr_gnt: got %b want 10", gnt); end
        n_checks++; if (dreq !== 2'b10) begin n_fail++; $display("FAIL wr_dreq: got %b want 10", dreq); end
        n_checks++; if (dwdata[63:32] !== 32'h41) begin n_fail++; $display("FAIL wr_wdata: got %h want 00000041", dwdata[63:32]); end
        n_checks++; if (dwe !== 2'b11)  begin n_fail++; $display("FAIL wr_we: got %b want 11", dwe); end
        next_cycle();
        clear_hosts();
        @(negedge clk);
        n_checks++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL wr_rvalid: got %b want 10", rvalid); end
        n_checks++; if (rdata !== 64'h0)  begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rdata); end
        n_checks++; if (herr !== 2'b00)   begin n_fail++; $display("FAIL wr_err: got %b want 00", herr); end
        $display("txn: H1 write 0x00200000 <- 0x41 acked");
        next_cycle();
    endtask

    task automatic test_decode_error();
        rst = 1'b1; next_cycle(); rst = 1'b0;
        drive_host(0, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b01)  begin n_fail++; $display("FAIL derr_gnt: got %b want 01", gnt); end
        n_checks++; if (dreq !== 2'b00) begin n_fail++; $display("FAIL derr_dreq: got %b want 00", dreq); end
        n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL derr_cnt0: got %0d want 0", err_cnt); end
        next_cycle();
        clear_hosts();
        @(negedge clk);
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL derr_rvalid: got %b want 01", rvalid); end
        n_checks++; if (herr !== 2'b01)   begin n_fail++; $display("FAIL derr_err: got %b want 01", herr); end
        n_checks++; if (rdata !== 64'h0)  begin n_fail++; $display("FAIL derr_rdata: got %h want 0", rdata); end
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL derr_cnt1: got %0d want 1", err_cnt); end
        $display("txn: H0 read 0x80000000 -> decode error");
        drive_host(0, 1'b1, 32'h8000_0000, 1'b0, 32'h0);
        for (int c = 0; c < 4; c++) next_cycle();
        clear_hosts();
        @(negedge clk);
        n_checks++; if (err_cnt !== 16'd5)  begin n_fail++; $display("FAIL derr_cnt5: got %0d want 5", err_cnt); end
        n_checks++; if (s_err_cnt !== 2'd3) begin n_fail++; $display("FAIL derr_sat: got %0d want 3", s_err_cnt); end
        $display("txn: 5 decode errors, counters %0d / %0d", err_cnt, s_err_cnt);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; next_cycle(); rst = 1'b0;
        drive_host(0, 1'b1, 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gntA: got %b want 01", gnt); end
        next_cycle();
        drive_host(0, 1'b1, 32'h0020_0040, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++; if (gnt !== 2'b01)    begin n_fail++; $display("FAIL b2b_gntB: got %b want 01", gnt); end
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL b2b_rvA: got %b want 01", rvalid); end
        n_checks++; if (rdata[31:0] !== 32'hDEAD_BFFF) begin n_fail++; $display("FAIL b2b_dataA: got %h want deadbfff", rdata[31:0]); end
        next_cycle();
        clear_hosts();
        @(negedge clk);
        n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL b2b_rvB: got %b want 01", rvalid); end
        n_checks++; if (rdata[31:0] !== 32'h1214_5638) begin n_fail++; $display("FAIL b2b_dataB: got %h want 12145638", rdata[31:0]); end
        $display("txn: H0 back-to-back reads A/B returned");
        next_cycle();
        // Reset rising in the cycle B would be granted: B is dropped.
        drive_host(0, 1'b1, 32'h100, 1'b0, 32'h0);
        next_cycle();
        drive_host(0, 1'b1, 32'h0020_0040, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_rst_gnt: got %b want 00", gnt); end
        next_cycle();
        rst = 1'b0;
        clear_hosts();
        @(negedge clk);
        n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rst_rvalid: got %b want 00", rvalid); end
        $display("txn: reset during grant of B, no response");
        next_cycle();
    endtask

    task automatic test_random(int ncyc);
        bit          pend[NH] = '{default: 1'b0};
        logic [31:0] pa[NH]   = '{default: 32'h0};
        logic        pw[NH]   = '{default: 1'b0};
        logic [31:0] pd[NH]   = '{default: 32'h0};
        logic [3:0]  pb[NH]   = '{default: 4'h0};
        int rr = 0, g, dev, ecnt = 0, rh = 0, rd = 0;
        bit rv = 1'b0, rwe = 1'b0;
        logic [31:0] ra = '0;
        logic [NH-1:0] exp_gnt, exp_rv, exp_err;
        logic [ND-1:0] exp_dreq;
        logic [NH*DW-1:0] exp_rdata;
        rst = 1'b1; clear_hosts(); next_cycle(); rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            for (int h = 0; h < NH; h++) begin
                if (!pend[h] && $urandom_range(0, 9) < 6) begin
                    pend[h] = 1'b1; pa[h] = rand_addr(); pw[h] = 1'($urandom_range(0, 1));
                    pd[h] = $urandom; pb[h] = 4'($urandom);
                end
                host_req[h] = pend[h]; host_addr[h*AW +: AW] = pa[h]; host_we[h] = pw[h];
                host_be[h*BW +: BW] = pb[h]; host_wdata[h*DW +: DW] = pd[h];
            end
            g = -1;
            for (int k = 0; k < NH; k++) if (g < 0 && pend[(rr + k) % NH]) g = (rr + k) % NH;
            dev = (g >= 0) ? ref_decode(pa[g]) : -1;
            exp_gnt = '0; exp_dreq = '0; exp_rv = '0; exp_err = '0; exp_rdata = '0;
            if (g >= 0) exp_gnt[g] = 1'b1;
            if (dev >= 0) exp_dreq[dev] = 1'b1;
            if (rv) begin
                exp_rv[rh] = 1'b1;
                exp_err[rh] = (rd < 0);
                if (!rwe && rd >= 0) exp_rdata[rh*DW +: DW] = dev_data(rd, ra);
            end
            @(negedge clk);
            n_checks++; if (gnt !== exp_gnt)   begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, exp_gnt); end
            n_checks++; if (dreq !== exp_dreq) begin n_fail++; $display("FAIL rnd_dreq c%0d: got %b want %b", c, dreq, exp_dreq); end
            n_checks++; if (daddr !== ((g >= 0) ? {2{pa[g]}} : 64'h0)) begin n_fail++; $display("FAIL rnd_daddr c%0d: got %h", c, daddr); end
            n_checks++; if (dwdata !== ((g >= 0) ? {2{pd[g]}} : 64'h0)) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h", c, dwdata); end
            n_checks++; if (dbe !== ((g >= 0) ? {2{pb[g]}} : 8'h0)) begin n_fail++; $display("FAIL rnd_be c%0d: got %h", c, dbe); end
            n_checks++; if (dwe !== ((g >= 0) ? {2{pw[g]}} : 2'b00)) begin n_fail++; $display("FAIL rnd_we c%0d: got %b", c, dwe); end
            n_checks++; if (rvalid !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, exp_rv); end
            n_checks++; if (herr !== exp_err)  begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, herr, exp_err); end
            n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, exp_rdata); end
            n_checks++; if (err_cnt !== 16'(ecnt)) begin n_fail++; $display("FAIL rnd_errcnt c%0d: got %0d want %0d", c, err_cnt, ecnt); end
            if (g >= 0) $display("txn: c%0d H%0d %s addr=%h dev=%0d", c, g, pw[g] ? "wr" : "rd", pa[g], dev);
            @(posedge clk);
            if (g >= 0) begin
                rr = (g + 1) % NH; rv = 1'b1; rh = g; rd = dev; rwe = pw[g]; ra = pa[g];
                if (dev < 0 && ecnt < 65535) ecnt++;
                pend[g] = 1'b0;
            end else begin
                rv = 1'b0;
            end
            #1;
        end
        clear_hosts();
    endtask

    initial begin
        rst = 1'b1;
        clear_hosts();
        next_cycle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_decode_error();
        test_back_to_back();
        test_random(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
